// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: pixel type and window-generator FSM encoding.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One-line delay memory: the read at addr returns the value written one line ago,
// and the new value replaces it on the same clock edge (read-before-write).
module sobel_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Unreset storage so the array maps onto distributed RAM.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting register window,
// emitting only interior windows of each raster-order frame.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = sobel_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] p00,
    output logic [PIX_W-1:0] p01,
    output logic [PIX_W-1:0] p02,
    output logic [PIX_W-1:0] p10,
    output logic [PIX_W-1:0] p11,
    output logic [PIX_W-1:0] p12,
    output logic [PIX_W-1:0] p20,
    output logic [PIX_W-1:0] p21,
    output logic [PIX_W-1:0] p22,
    output logic             win_valid,
    output logic             win_last,
    output logic             busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [CW-1:0]    c_eff;
    logic [RW-1:0]    r_eff;
    logic             start;
    logic             accept;
    logic             last_pix;
    logic             interior;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] win [3][3];

    // A qualified sof is accepted in every state and forces the pixel to (0,0).
    assign start    = pix_valid && sof;
    assign accept   = start || (pix_valid && (state == ST_ACTIVE));
    assign c_eff    = start ? '0 : col;
    assign r_eff    = start ? '0 : row;
    assign last_pix = (r_eff == ROW_MAX) && (c_eff == COL_MAX);
    assign interior = (r_eff >= RW'(2)) && (c_eff >= CW'(2));
    assign busy     = (state == ST_ACTIVE);

    // LB1 holds the previous line; its displaced value cascades into LB0.
    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .en      (accept),
        .addr    (c_eff),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .en      (accept),
        .addr    (c_eff),
        .wr_data (pix_in),
        .rd_data (lb1_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ACTIVE;
        end else if ((state == ST_ACTIVE) && accept && last_pix) begin
            state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            win_valid <= accept && interior;
            win_last  <= accept && last_pix;
            if (accept) begin
                if (c_eff == COL_MAX) begin
                    col <= '0;
                    row <= last_pix ? '0 : r_eff + RW'(1);
                end else begin
                    col <= c_eff + CW'(1);
                    row <= r_eff;
                end
                // Shift left; the new right column is two lines back, one line back, current.
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb0_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= pix_in;
            end
        end
    end

    assign p00 = win[0][0];
    assign p01 = win[0][1];
    assign p02 = win[0][2];
    assign p10 = win[1][0];
    assign p11 = win[1][1];
    assign p12 = win[1][2];
    assign p20 = win[2][0];
    assign p21 = win[2][1];
    assign p22 = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for the 3x3 window generator on a 4x4 frame whose pixels are r*4+c+1.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pix_t pix_in = '0;
    logic pix_valid = 1'b0;
    logic sof = 1'b0;
    pix_t p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic win_valid, win_last, busy;

    int n_checks = 0;
    int n_fail = 0;

    logic [71:0] cap_win[$];
    bit          cap_last[$];
    int          cap_at[$];
    int          idle_pulses;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .p00       (p00),
        .p01       (p01),
        .p02       (p02),
        .p10       (p10),
        .p11       (p11),
        .p12       (p12),
        .p20       (p20),
        .p21       (p21),
        .p22       (p22),
        .win_valid (win_valid),
        .win_last  (win_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] cur_win();
        return {p00, p01, p02, p10, p11, p12, p20, p21, p22};
    endfunction

    // Expected window whose top-left pixel is (r0,c0).
    function automatic logic [71:0] exp_win(input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[71 - 8*(i*3 + j) -: 8] = 8'((r0 + i) * W + (c0 + j) + 1);
        return w;
    endfunction

    task automatic clear_cap();
        cap_win.delete();
        cap_last.delete();
        cap_at.delete();
        idle_pulses = 0;
    endtask

    task automatic drive(input bit v, input bit s, input int px);
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        pix_in    = 8'(px);
        @(posedge clk);
        #1;
        if (win_valid === 1'b1) begin
            cap_win.push_back(cur_win());
            cap_last.push_back(win_last);
            cap_at.push_back(px);
            if (!v) idle_pulses++;
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    while ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 0);
                end
                drive(1'b1, (r == 0) && (c == 0), r * W + c + 1);
            end
        end
        drive(1'b0, 1'b0, 0);
    endtask

    task automatic check_four(input string tag);
        n_checks++;
        if (cap_win.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL %s_count: got %0d windows, expected 4", tag, cap_win.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (cap_win[k] !== exp_win(k / 2, k % 2) || cap_last[k] !== (k == 3)) begin
                    n_fail++;
                    $display("[TB] FAIL %s_win%0d: got %h last=%0b, expected %h last=%0b",
                             tag, k, cap_win[k], cap_last[k], exp_win(k / 2, k % 2), (k == 3));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({cur_win(), win_valid, win_last, busy} !== 75'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", {cur_win(), win_valid, win_last, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        clear_cap();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, (r == 0) && (c == 0), r * W + c + 1);
                if (r * W + c + 1 == 15) begin
                    n_checks++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("[TB] FAIL busy_active: got %0b, expected 1", busy);
                    end
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_done: got %0b, expected 0", busy);
        end
        drive(1'b0, 1'b0, 0);
        check_four("cont");
        n_checks++;
        if (cap_at.size() < 1 || cap_at[0] !== 11) begin
            n_fail++;
            $display("[TB] FAIL first_window_timing: got pixel %0d, expected 11",
                     (cap_at.size() > 0) ? cap_at[0] : -1);
        end
    endtask

    task automatic test_gaps();
        clear_cap();
        send_frame(1'b1);
        check_four("gaps");
        n_checks++;
        if (idle_pulses !== 0) begin
            n_fail++;
            $display("[TB] FAIL gaps_idle_pulse: got %0d, expected 0", idle_pulses);
        end
    endtask

    task automatic test_mid_sof();
        clear_cap();
        for (int px = 1; px <= 7; px++) drive(1'b1, px == 1, px);
        n_checks++;
        if (cap_win.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL midsof_spurious: got %0d windows, expected 0", cap_win.size());
        end
        send_frame(1'b0);
        check_four("midsof");
    endtask

    task automatic test_reset_mid_frame();
        clear_cap();
        for (int px = 1; px <= 8; px++) drive(1'b1, px == 1, px);
        @(negedge clk);
        pix_valid = 1'b1;
        sof       = 1'b0;
        pix_in    = 8'd9;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cur_win(), win_valid, win_last, busy} !== 75'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h, expected 0", {cur_win(), win_valid, win_last, busy});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int px = 10; px <= 12; px++) drive(1'b1, 1'b0, px);
        n_checks++;
        if (cap_win.size() !== 0 || busy !== 1'b0 || p22 !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_ignore: got wins=%0d busy=%0b p22=%0d, expected 0/0/0",
                     cap_win.size(), busy, p22);
        end
        send_frame(1'b0);
        check_four("rstframe");
    endtask

    task automatic test_after_done();
        clear_cap();
        for (int px = 1; px <= W * H; px++) drive(1'b1, 1'b0, px);
        n_checks++;
        if (cap_win.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL after_done: got wins=%0d busy=%0b, expected 0/0", cap_win.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_mid_sof();
        test_reset_mid_frame();
        test_after_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
